bus_arbiter: RTL and testbench

Parametrised, registered shared-bus driver for the CPU datapath: replaces the bare one-hot-enable bus mux with a request/grant arbiter. COUNT sources, each WIDTH bits wide, request the bus. One winner per cycle is selected by fixed-priority or round-robin policy, with optional lock for multi-cycle ownership and a starvation cap. The granted source's data is registered onto the bus output together with grant, owner index and valid.

---
 rtl/bus_arbiter_pkg.sv | 30 +++
 rtl/bus_arbiter_if.sv | 30 +++
 rtl/bus_arbiter_rr_pick.sv | 20 ++
 rtl/bus_arbiter.sv | 91 +++++++++
 tb/tb_bus_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: policy codes, FSM states and small
// helpers used by the arbiter, its interface and its round-robin picker.
package bus_arbiter_pkg;

  localparam int BUS_MODE_FIXED = 0;
  localparam int BUS_MODE_RR    = 1;

  localparam int MAX_COUNT = 16;
  localparam int HOLD_W    = 8;

  typedef enum logic {
    BUS_ST_IDLE  = 1'b0,
    BUS_ST_OWNED = 1'b1
  } bus_state_e;

  // Owner index width; a single-source bus still carries a 1-bit index.
  function automatic int owner_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic logic [3:0] onehot_to_idx(input logic [MAX_COUNT-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_COUNT; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Shared-bus bundle: sources drive data/requests (master), the arbiter drives
// the registered grant, owner index and bus value (slave).
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
);

  localparam int OW = owner_w(COUNT);

  logic [WIDTH*COUNT-1:0] in;
  logic [COUNT-1:0]       req;
  logic                   lock;
  logic [COUNT-1:0]       grant;
  logic [OW-1:0]          owner;
  logic [WIDTH-1:0]       out;
  logic                   valid;

  modport master (
    output in, req, lock,
    input  grant, owner, out, valid
  );

  modport slave (
    input  in, req, lock,
    output grant, owner, out, valid
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// One-hot picker: returns the first set req bit at or above the one-hot start
// position, wrapping around; start = bit 0 degenerates to lowest-index-wins.
module rr_pick #(
  parameter int COUNT = 4
) (
  input  logic [COUNT-1:0] req,
  input  logic [COUNT-1:0] start,
  output logic [COUNT-1:0] win
);

  logic [2*COUNT-1:0] dreq;
  logic [2*COUNT-1:0] dgnt;

  // Subtracting the start bit from the doubled request vector borrows through
  // the zeros below the first request at/after start; masking isolates it.
  assign dreq = {req, req};
  assign dgnt = dreq & ~(dreq - {{COUNT{1'b0}}, start});
  assign win  = dgnt[COUNT-1:0] | dgnt[2*COUNT-1:COUNT];

endmodule

// File: rtl/bus_arbiter.sv
// Registered shared-bus arbiter: fixed-priority or round-robin grant with
// optional owner lock bounded by a hold cap; winner's data is registered out.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int COUNT    = 4,
  parameter int MODE     = BUS_MODE_FIXED,
  parameter int HOLD     = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_arbiter_if.slave    bus
);

  localparam int                OW         = owner_w(COUNT);
  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

  bus_state_e        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [OW-1:0]     rr_ptr;

  logic [COUNT-1:0]  start;
  logic [COUNT-1:0]  win;
  logic [OW-1:0]     win_idx;
  logic [OW-1:0]     next_idx;
  logic [WIDTH-1:0]  data_sel;
  logic              keep;
  int                nxt;

  // Search origin: bit 0 for fixed priority, one past the last winner for RR.
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    nxt = 0;
    if (MODE == BUS_MODE_RR && int'(rr_ptr) < COUNT - 1) nxt = int'(rr_ptr) + 1;
    start      = '0;
    start[nxt] = 1'b1;
  end

  rr_pick #(.COUNT(COUNT)) u_pick (
    .req   (bus.req),
    .start (start),
    .win   (win)
  );

  assign win_idx = OW'(onehot_to_idx(MAX_COUNT'(win)));

  // Once the cap is reached the owner loses its lock and must re-arbitrate;
  // in RR mode rr_ptr already points at it, so it has lowest priority.
  assign keep = (state == BUS_ST_OWNED) && bus.req[bus.owner] && bus.lock &&
                (hold_cnt < MAX_HOLD_C);

  assign next_idx = keep ? bus.owner : win_idx;
  assign data_sel = bus.in[int'(next_idx)*WIDTH +: WIDTH];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and covers every register here; there is no
    // storage array, so nothing is left to power up undefined.
    if (!rst_n) begin
      state     <= BUS_ST_IDLE;
      hold_cnt  <= '0;
      rr_ptr    <= OW'(COUNT - 1);
      bus.grant <= '0;
      bus.owner <= '0;
      bus.out   <= '0;
      bus.valid <= 1'b0;
    end else if (keep) begin
      hold_cnt  <= hold_cnt + HOLD_W'(1);
      bus.out   <= data_sel;
      bus.valid <= 1'b1;
    end else if (|bus.req) begin
      state     <= BUS_ST_OWNED;
      hold_cnt  <= HOLD_W'(1);
      rr_ptr    <= win_idx;
      bus.grant <= win;
      bus.owner <= win_idx;
      bus.out   <= data_sel;
      bus.valid <= 1'b1;
    end else begin
      state     <= BUS_ST_IDLE;
      bus.grant <= '0;
      bus.valid <= 1'b0;
      if (HOLD == 0) bus.out <= '0;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Drives two arbiter builds (fixed/HOLD=1/cap 8 and round-robin/HOLD=0/cap 3)
// with directed and random traffic, checked against a behavioural model.
module tb_bus_arbiter;

  localparam int WIDTH = 8;
  localparam int COUNT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [WIDTH*COUNT-1:0] din;
  logic [COUNT-1:0]       req;
  logic                   lock;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.WIDTH(WIDTH), .COUNT(COUNT)) ifa ();
  bus_arbiter_if #(.WIDTH(WIDTH), .COUNT(COUNT)) ifb ();

  assign ifa.in   = din;
  assign ifa.req  = req;
  assign ifa.lock = lock;
  assign ifb.in   = din;
  assign ifb.req  = req;
  assign ifb.lock = lock;

  bus_arbiter #(.WIDTH(WIDTH), .COUNT(COUNT), .MODE(0), .HOLD(1), .MAX_HOLD(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  bus_arbiter #(.WIDTH(WIDTH), .COUNT(COUNT), .MODE(1), .HOLD(0), .MAX_HOLD(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  // Behavioural model, one slot per build.
  int cfg_mode [2] = '{0, 1};
  int cfg_hold [2] = '{1, 0};
  int cfg_mh   [2] = '{8, 3};

  int m_owned [2];
  int m_owner [2];
  int m_cnt   [2];
  int m_last  [2];
  int m_out   [2];
  int m_valid [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int chan(input int i);
    logic [WIDTH*COUNT-1:0] d;
    d = din;
    return int'(d[i*WIDTH +: WIDTH]);
  endfunction

  task automatic model_step(input int d);
    int w;
    int idx;
    bit keep;
    if (!rst_n) begin
      m_owned[d] = 0; m_owner[d] = 0; m_cnt[d] = 0;
      m_last[d]  = COUNT - 1; m_out[d] = 0; m_valid[d] = 0;
      return;
    end
    keep = m_owned[d] != 0 && req[m_owner[d]] && lock && m_cnt[d] < cfg_mh[d];
    if (keep) begin
      m_cnt[d]++;
      m_out[d]   = chan(m_owner[d]);
      m_valid[d] = 1;
    end else if (req != '0) begin
      w = -1;
      for (int k = 1; k <= COUNT; k++) begin
        idx = (cfg_mode[d] == 0) ? k - 1 : (m_last[d] + k) % COUNT;
        if (w < 0 && req[idx]) w = idx;
      end
      m_owned[d] = 1; m_owner[d] = w; m_cnt[d] = 1; m_last[d] = w;
      m_out[d]   = chan(w);
      m_valid[d] = 1;
    end else begin
      m_owned[d] = 0;
      m_valid[d] = 0;
      if (cfg_hold[d] == 0) m_out[d] = 0;
    end
  endtask

  task automatic check_dut(input string nm, input int d, input logic [COUNT-1:0] g,
                           input logic [1:0] o, input logic [WIDTH-1:0] q, input logic v);
    logic [COUNT-1:0] exp_g;
    exp_g = (m_valid[d] != 0) ? COUNT'(1 << m_owner[d]) : '0;
    check({nm, ".onehot0"}, 32'($onehot0(g)), 32'd1);
    if (g != '0) check({nm, ".owner_bit"}, 32'(g[o]), 32'd1);
    check({nm, ".grant"}, 32'(g), 32'(exp_g));
    check({nm, ".owner"}, 32'(o), 32'(m_owner[d]));
    check({nm, ".out"},   32'(q), 32'(m_out[d]));
    check({nm, ".valid"}, 32'(v), 32'(m_valid[d]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_dut("A", 0, ifa.grant, ifa.owner, ifa.out, ifa.valid);
    check_dut("B", 1, ifb.grant, ifb.owner, ifb.out, ifb.valid);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; lock = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [COUNT-1:0] seq_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0]       seq_o [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [COUNT-1:0] lk_g  [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0001};

  initial begin
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    rst_n = 1'b0; req = '0; lock = 1'b0;
    tick();
    tick();
    check("rst.grant", 32'(ifa.grant), 32'd0);
    check("rst.out",   32'(ifa.out),   32'h00);
    check("rst.valid", 32'(ifa.valid), 32'd0);
    rst_n = 1'b1;
    tick();
    req = 4'b0001;
    tick();
    check("first.grant", 32'(ifa.grant), 32'b0001);
    check("first.owner", 32'(ifa.owner), 32'd0);
    check("first.out",   32'(ifa.out),   32'h11);
    check("first.valid", 32'(ifa.valid), 32'd1);

    // Fixed priority handover and idle behaviour of both HOLD settings.
    do_reset();
    req = 4'b1010;
    tick();
    check("fix.g0", 32'(ifa.grant), 32'b0010);
    check("fix.o0", 32'(ifa.out),   32'h22);
    tick();
    check("fix.g1", 32'(ifa.grant), 32'b0010);
    req = 4'b1000;
    tick();
    check("fix.g2", 32'(ifa.grant), 32'b1000);
    check("fix.o2", 32'(ifa.out),   32'h44);
    req = 4'b0000;
    tick();
    check("idle.valid", 32'(ifa.valid), 32'd0);
    check("idle.hold1", 32'(ifa.out),   32'h44);
    check("idle.hold0", 32'(ifb.out),   32'h00);

    // Round-robin rotation without lock.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr.grant", 32'(ifb.grant), 32'(seq_g[i]));
      check("rr.out",   32'(ifb.out),   32'(seq_o[i]));
    end

    // Lock with hold cap of 3 on the round-robin build.
    do_reset();
    req = 4'b0101; lock = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("lock.grant", 32'(ifb.grant), 32'(lk_g[i]));
    end

    // Reset in the middle of an ownership.
    do_reset();
    req = 4'b0100; lock = 1'b1;
    tick();
    check("mid.pre", 32'(ifb.grant), 32'b0100);
    rst_n = 1'b0;
    tick();
    check("mid.grant", 32'(ifb.grant), 32'd0);
    check("mid.out",   32'(ifb.out),   32'd0);
    check("mid.outA",  32'(ifa.out),   32'd0);
    rst_n = 1'b1; req = 4'b1111; lock = 1'b0;
    tick();
    check("mid.first", 32'(ifb.grant), 32'b0001);

    // Random traffic with occasional resets; lock biased high.
    for (int i = 0; i < 10000; i++) begin
      din   = $urandom;
      req   = COUNT'($urandom);
      lock  = ($urandom_range(3) != 0);
      rst_n = ($urandom_range(499) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
